// File: rtl/seg_pkg.sv
// Shared types and defaults for the seven-segment display scheduler.
package seg_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_e;

    localparam logic [15:0] BLANK_DEFAULT = 16'h0000;

    // One second of dwell at a 50 MHz board clock.
    localparam int unsigned DWELL_50MHZ = 50_000_000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request after last_i, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic [NREQ-1:0] win_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    int unsigned pos;
    logic        found;

    always_comb begin
        win_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            pos = (int'(last_i) + k) % NREQ;
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                win_o[pos] = 1'b1;
                idx_o      = IDW'(pos);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-shares one 4-digit seven-segment display among NREQ requesters with round-robin dwell.
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2,
    parameter int unsigned DWELL = DWELL_50MHZ,
    parameter int unsigned CNT_W = 26,
    parameter logic [15:0] BLANK = BLANK_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*16-1:0] data_in,
    input  logic               next_btn,
    input  logic               lock,
    output logic [NREQ-1:0]    grant,
    output logic [IDW-1:0]     active_id,
    output logic [15:0]        disp_data,
    output logic               busy
);

    state_e          state_q;
    logic [NREQ-1:0] grant_q;
    logic [IDW-1:0]  active_id_q;
    logic [IDW-1:0]  last_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]     disp_q;
    logic            busy_q;

    logic [NREQ-1:0] arb_win;
    logic [IDW-1:0]  arb_idx;
    logic            arb_any;
    logic [15:0]     cur_data;

    localparam logic [CNT_W-1:0] Reload = CNT_W'(DWELL - 1);

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i  (req),
        .last_i (last_q),
        .win_o  (arb_win),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    always_comb begin
        cur_data = BLANK;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_q[i]) begin
                cur_data = data_in[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            active_id_q <= '0;
            last_q      <= IDW'(NREQ - 1);
            cnt_q       <= '0;
            disp_q      <= BLANK;
            busy_q      <= 1'b0;
        end else begin
            // Output register follows the grant held before this edge.
            disp_q <= cur_data;
            unique case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        state_q     <= ST_SHOW;
                        grant_q     <= arb_win;
                        active_id_q <= arb_idx;
                        last_q      <= arb_idx;
                        cnt_q       <= Reload;
                        busy_q      <= 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (!req[active_id_q]) begin
                        if (arb_any) begin
                            grant_q     <= arb_win;
                            active_id_q <= arb_idx;
                            last_q      <= arb_idx;
                            cnt_q       <= Reload;
                        end else begin
                            state_q     <= ST_IDLE;
                            grant_q     <= '0;
                            active_id_q <= '0;
                            busy_q      <= 1'b0;
                        end
                    end else if (lock) begin
                        cnt_q <= cnt_q;
                    end else if (cnt_q == '0 || next_btn) begin
                        // The current holder still requests, so the arbiter always finds a winner.
                        grant_q     <= arb_win;
                        active_id_q <= arb_idx;
                        last_q      <= arb_idx;
                        cnt_q       <= Reload;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign active_id = active_id_q;
    assign disp_data = disp_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Self-checking bench: hand-derived vector table plus a reference-model scoreboard.
module tb_seg_display_scheduler;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDW   = 2;
    localparam int unsigned DWELL = 8;
    localparam int unsigned CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] data_in;
    logic        next_btn;
    logic        lock;
    logic [3:0]  grant;
    logic [1:0]  active_id;
    logic [15:0] disp_data;
    logic        busy;

    seg_display_scheduler #(
        .NREQ  (NREQ),
        .IDW   (IDW),
        .DWELL (DWELL),
        .CNT_W (CNT_W),
        .BLANK (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .next_btn  (next_btn),
        .lock      (lock),
        .grant     (grant),
        .active_id (active_id),
        .disp_data (disp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  grant;
        logic [1:0]  id;
        logic [15:0] disp;
        logic        busy;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic       nb;
        logic       lk;
        obs_t       exp;
    } vec_t;

    obs_t sb_q[$];
    vec_t tbl[15];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    logic [3:0]  m_grant = 4'b0;
    int          m_id    = 0;
    int          m_last  = 3;
    int          m_cnt   = 0;
    logic        m_busy  = 1'b0;

    task automatic drive(input logic r, input logic [3:0] rq, input logic nb, input logic lk);
        rst      = r;
        req      = rq;
        next_btn = nb;
        lock     = lk;
    endtask

    task automatic check_edge(input string tag);
        obs_t act;
        obs_t exp;
        @(posedge clk);
        #1;
        act = '{grant, active_id, disp_data, busy};
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got grant=%b", tag, grant);
        end else begin
            exp = sb_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s: got grant=%b id=%0d disp=%h busy=%b, want grant=%b id=%0d disp=%h busy=%b",
                         tag, act.grant, act.id, act.disp, act.busy,
                         exp.grant, exp.id, exp.disp, exp.busy);
            end
        end
        n_tests++;
        if (!$onehot0(grant) || (grant != 4'b0 && grant[active_id] !== 1'b1) ||
            (grant == 4'b0 && active_id != 2'd0) || busy !== (grant != 4'b0)) begin
            n_fail++;
            $display("FAIL %s invariant: grant=%b id=%0d busy=%b", tag, grant, active_id, busy);
        end
    endtask

    function automatic int pick(input logic [3:0] rq);
        for (int k = 1; k <= 4; k++) begin
            if (rq[(m_last + k) % 4]) return (m_last + k) % 4;
        end
        return -1;
    endfunction

    task automatic issue(input int w);
        m_grant = 4'b0001 << w;
        m_id    = w;
        m_last  = w;
        m_cnt   = DWELL - 1;
        m_busy  = 1'b1;
    endtask

    task automatic model_step(input logic r, input logic [3:0] rq, input logic nb, input logic lk);
        logic [15:0] nd;
        int w;
        nd = (m_grant == 4'b0) ? 16'h0000 : data_in[m_id*16 +: 16];
        if (r) begin
            m_grant = 4'b0; m_id = 0; m_last = 3; m_cnt = 0; m_busy = 1'b0; nd = 16'h0000;
        end else if (!m_busy) begin
            w = pick(rq);
            if (w >= 0) issue(w);
        end else if (!rq[m_id]) begin
            w = pick(rq);
            if (w >= 0) issue(w);
            else begin
                m_grant = 4'b0; m_id = 0; m_busy = 1'b0;
            end
        end else if (!lk) begin
            if (m_cnt == 0 || nb) issue(pick(rq));
            else m_cnt--;
        end
        sb_q.push_back('{m_grant, 2'(m_id), nd, m_busy});
    endtask

    task automatic mstep(input logic r, input logic [3:0] rq, input logic nb, input logic lk,
                         input string tag);
        drive(r, rq, nb, lk);
        model_step(r, rq, nb, lk);
        check_edge(tag);
    endtask

    task automatic mrun(input logic r, input logic [3:0] rq, input logic nb, input logic lk,
                        input int n, input string tag);
        for (int i = 0; i < n; i++) mstep(r, rq, nb, lk, tag);
    endtask

    initial begin
        data_in = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        drive(1'b1, 4'b0, 1'b0, 1'b0);

        // Hand-derived: reset, basic grant, next_btn, lock ignore, release-while-locked, idle, reset.
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, '{4'b0000, 2'd0, 16'h0000, 1'b0}};
        tbl[1]  = '{1'b1, 4'b0000, 1'b0, 1'b0, '{4'b0000, 2'd0, 16'h0000, 1'b0}};
        tbl[2]  = '{1'b0, 4'b0001, 1'b0, 1'b0, '{4'b0001, 2'd0, 16'h0000, 1'b1}};
        tbl[3]  = '{1'b0, 4'b0001, 1'b0, 1'b0, '{4'b0001, 2'd0, 16'hAAAA, 1'b1}};
        tbl[4]  = '{1'b0, 4'b1011, 1'b1, 1'b0, '{4'b0010, 2'd1, 16'hAAAA, 1'b1}};
        tbl[5]  = '{1'b0, 4'b1011, 1'b0, 1'b0, '{4'b0010, 2'd1, 16'hBBBB, 1'b1}};
        tbl[6]  = '{1'b0, 4'b1011, 1'b1, 1'b1, '{4'b0010, 2'd1, 16'hBBBB, 1'b1}};
        tbl[7]  = '{1'b0, 4'b1001, 1'b0, 1'b1, '{4'b1000, 2'd3, 16'hBBBB, 1'b1}};
        tbl[8]  = '{1'b0, 4'b1001, 1'b0, 1'b0, '{4'b1000, 2'd3, 16'hDDDD, 1'b1}};
        tbl[9]  = '{1'b0, 4'b1001, 1'b1, 1'b0, '{4'b0001, 2'd0, 16'hDDDD, 1'b1}};
        tbl[10] = '{1'b0, 4'b0000, 1'b0, 1'b0, '{4'b0000, 2'd0, 16'hAAAA, 1'b0}};
        tbl[11] = '{1'b0, 4'b0000, 1'b0, 1'b0, '{4'b0000, 2'd0, 16'h0000, 1'b0}};
        tbl[12] = '{1'b1, 4'b0100, 1'b0, 1'b0, '{4'b0000, 2'd0, 16'h0000, 1'b0}};
        tbl[13] = '{1'b0, 4'b0100, 1'b0, 1'b0, '{4'b0100, 2'd2, 16'h0000, 1'b1}};
        tbl[14] = '{1'b0, 4'b0100, 1'b0, 1'b0, '{4'b0100, 2'd2, 16'hCCCC, 1'b1}};

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].nb, tbl[i].lk);
            sb_q.push_back(tbl[i].exp);
            check_edge($sformatf("vec%0d", i));
        end

        // Rotation over three requesters, full dwell each.
        mrun(1'b1, 4'b0000, 1'b0, 1'b0, 2, "rot_rst");
        mrun(1'b0, 4'b1011, 1'b0, 1'b0, 34, "rotation");

        // Manual advance mid-dwell, then next_btn coinciding with counter==0.
        mrun(1'b1, 4'b0000, 1'b0, 1'b0, 1, "adv_rst");
        mrun(1'b0, 4'b1111, 1'b0, 1'b0, 4, "adv_pre");
        mstep(1'b0, 4'b1111, 1'b1, 1'b0, "adv_btn");
        for (int i = 0; i < 20; i++) begin
            mstep(1'b0, 4'b1111, (m_cnt == 0 && i < 12), 1'b0, "coincide");
        end

        // Lock on grant 0010, release by dropping req[1], then resume and idle.
        mrun(1'b1, 4'b0000, 1'b0, 1'b0, 1, "lock_rst");
        mstep(1'b0, 4'b1111, 1'b0, 1'b0, "lock_g0");
        mstep(1'b0, 4'b1111, 1'b1, 1'b0, "lock_g1");
        for (int i = 0; i < 30; i++) mstep(1'b0, 4'b1111, (i % 5 == 2), 1'b1, "locked");
        mrun(1'b0, 4'b1101, 1'b0, 1'b1, 4, "lock_drop");
        mrun(1'b0, 4'b1101, 1'b0, 1'b0, 12, "lock_resume");
        mrun(1'b0, 4'b0000, 1'b0, 1'b0, 3, "all_drop");

        // Reset mid-SHOW holding grant 1000.
        mrun(1'b0, 4'b1000, 1'b0, 1'b0, 4, "mid_show");
        mstep(1'b1, 4'b1111, 1'b0, 1'b0, "mid_rst");
        mstep(1'b0, 4'b1111, 1'b0, 1'b0, "post_rst");
        n_tests++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL first_after_rst: got grant=%b, want 0001", grant);
        end

        // Random traffic with live data changes.
        for (int i = 0; i < 300; i++) begin
            data_in = {$urandom, $urandom};
            mstep(($urandom_range(0, 49) == 0), 4'($urandom), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) == 0), "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
Time-shares the single 4-digit seven-segment display among NREQ requesters, for example the CPU output register, PC debug and memory data. Round-robin dwell scheduling with manual advance and lock. Output drives the sevensegment module's 16-bit datain directly; digit multiplexing stays inside sevensegment.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of active_id; must satisfy 2^IDW >= NREQ
DWELL, 50_000_000, clk cycles each grant is shown before rotation (1 s at 50 MHz); must be >= 2
CNT_W, 26, dwell counter width; must satisfy 2^CNT_W > DWELL
BLANK, 16'h0000, value shown when no requester is granted

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  NREQ  per-requester "wants display" level
data_in  in  NREQ*16  packed values; requester i at [16*i+15:16*i]
next_btn  in  1  single-cycle pulse (already debounced) forcing early rotation
lock  in  1  level; freezes the current grant while high
grant  out  NREQ  one-hot grant, or all-zero
active_id  out  IDW  index of the granted requester; 0 when idle
disp_data  out  16  value to sevensegment datain
busy  out  1  high whenever a grant is held

Behaviour:
- Reset (rst high at posedge): state=IDLE, grant=0, active_id=0, disp_data=BLANK, busy=0, dwell counter=0, rr pointer last=NREQ-1 (so requester 0 wins first).
- States: IDLE, SHOW.
- Arbitration function: first i with req[i]=1, searched from (last+1) mod NREQ, wrapping.
- IDLE:
  - If any req=1, at the next edge go to SHOW, set grant/active_id to the winner, last=winner, counter=DWELL-1, busy=1.
  - Otherwise stay in IDLE.
- SHOW, evaluated in priority order each cycle:
  1. req[active_id]=0: release regardless of lock. Re-arbitrate among the remaining requesters at the next edge and reload the counter. If none remain, go to IDLE and clear grant/busy.
  2. lock=1: hold the grant; counter holds its value; next_btn ignored.
  3. counter==0 or next_btn=1: re-arbitrate from last+1. If the winner is the same requester (sole requester), keep the grant and reload the counter. Otherwise switch the grant and reload.
  4. Otherwise decrement the counter.
- next_btn and counter==0 in the same cycle count as one rotation, not two.
- Grant latency: req rising while IDLE -> grant valid 1 cycle later.
- disp_data: registered; each cycle disp_data <= data_in slice of the current registered grant, or BLANK if grant=0. Grant change -> disp_data change exactly 1 cycle later. Live data changes track with 1-cycle latency.
- Counter never underflows; it is reloaded only on a grant (re)issue.
- Lock deasserting resumes the decrement from the held value.
- rst mid-SHOW: all outputs return to reset values at that edge; the rr pointer is also reset.
- grant is always one-hot or zero; active_id is consistent with grant in every cycle.

Decomposition:
- Shared package seg_pkg:
  - State encoding constants (ST_IDLE, ST_SHOW).
  - BLANK default.
  - DWELL default for a 50 MHz board clock.
- One natural sub-module: rr_arbiter. Purely combinational; inputs req, last; outputs one-hot win and index. Reusable for other shared peripherals.
- The FSM, counter and output register live in the top.

Test Plan:
Bench uses NREQ=4, DWELL=8; data_in = {16'hDDDD,16'hCCCC,16'hBBBB,16'hAAAA}.
1. Reset: rst=1 for 2 cycles, req=0 -> grant=0, busy=0, active_id=0, disp_data=16'h0000.
2. Basic grant: req=4'b0001 at cycle 0 -> grant=0001 at cycle 1, disp_data=AAAA at cycle 2. Grant retained and counter reloaded every 8 cycles.
3. Rotation: req=4'b1011 held -> grant sequence 0001, 0010, 1000, 0001, changing every 8 cycles; disp_data follows AAAA, BBBB, DDDD, AAAA one cycle after each grant change.
4. Manual advance and coincidence:
   - With grant=0001 and req=1111, pulse next_btn at dwell cycle 3 -> grant=0010 next cycle and counter restarts.
   - next_btn coinciding with counter==0 -> advances one position only.
5. Lock:
   - lock=1 with grant=0010 for 30 cycles -> grant unchanged and next_btn ignored.
   - Drop req[1] while locked -> grant moves to 0100 next cycle.
   - Drop all req -> IDLE, disp_data=0000 one cycle after grant=0.
6. Reset mid-operation: rst mid-SHOW with grant=1000 -> outputs return to reset values. Releasing rst with req=1111 -> first grant=0001.
